// File: rtl/test_each_bist.sv
// test_each_bist: exhaustive-sweep BIST harness; drives every input vector into the block
// under test, counts ones per output, compacts responses into a MISR and grades against golden counts.
module test_each_bist #(
   parameter int NUM_IN = 6,
   parameter int NUM_OUT = 6,
   parameter int CNT_W = NUM_IN + 1,
   parameter int RESP_LAT = 0,
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF,
   parameter logic [NUM_OUT*CNT_W-1:0] EXP_CNT = {7'd52, 7'd12, 7'd60, 7'd4, 7'd48, 7'd16}
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   output logic [NUM_IN-1:0]        stim,
   input  logic [NUM_OUT-1:0]       resp,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [NUM_OUT*CNT_W-1:0] ones_cnt,
   output logic [SIG_W-1:0]         signature
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   localparam logic [1:0] DR_LAST = 2'(RESP_LAT > 0 ? RESP_LAT - 1 : 0);
   state_t r_state, w_next;
   logic [NUM_IN-1:0] r_stim;
   logic [1:0] r_drain;
   logic [NUM_OUT*CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_fin;
   logic [SIG_W-1:0] r_sig, w_sig_nxt;
   logic r_pass, w_last, w_clear, w_sample, w_enter_done;
   assign w_last = r_stim == '1;
   assign w_clear = (r_state == S_IDLE || r_state == S_DONE) && start && !abort;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_RUN : S_IDLE;
         S_RUN:   w_next = w_last ? (RESP_LAT == 0 ? S_DONE : S_DRAIN) : S_RUN;
         S_DRAIN: w_next = (r_drain == DR_LAST) ? S_DONE : S_DRAIN;
         S_DONE:  w_next = start ? S_RUN : S_DONE;
         default: w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end
   // Valid travels alongside stim so only the 2^NUM_IN real responses are sampled
   if (RESP_LAT == 0) begin : g_nolat
      assign w_sample = r_state == S_RUN;
   end else begin : g_lat
      logic [RESP_LAT-1:0] r_vpipe;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_vpipe <= '0;
         else r_vpipe <= abort ? '0 : (r_vpipe << 1) | RESP_LAT'(r_state == S_RUN);
      end
      assign w_sample = r_vpipe[RESP_LAT-1];
   end
   always_comb begin
      w_cnt_nxt = r_cnt;
      for (int i = 0; i < NUM_OUT; i++)
         w_cnt_nxt[i*CNT_W +: CNT_W] = r_cnt[i*CNT_W +: CNT_W] + CNT_W'(resp[i]);
   end
   assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(resp);
   assign w_cnt_fin = w_sample ? w_cnt_nxt : r_cnt;
   assign w_enter_done = w_next == S_DONE && r_state != S_DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_stim <= '0;
         r_drain <= '0;
         r_cnt <= '0;
         r_sig <= SIG_SEED;
         r_pass <= 1'b0;
      end else begin
         r_state <= w_next;
         r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
         if (w_clear) r_stim <= '0;
         else if (r_state == S_RUN && w_next == S_RUN) r_stim <= r_stim + NUM_IN'(1);
         if (w_clear) begin
            r_cnt <= '0;
            r_sig <= SIG_SEED;
         end else if (w_sample) begin
            r_cnt <= w_cnt_nxt;
            r_sig <= w_sig_nxt;
         end
         r_pass <= w_enter_done ? (w_cnt_fin == EXP_CNT) : (w_next == S_DONE) && r_pass;
      end
   end
   assign stim = r_stim;
   assign busy = r_state == S_RUN || r_state == S_DRAIN;
   assign done = r_state == S_DONE;
   assign pass = r_pass;
   assign ones_cnt = r_cnt;
   assign signature = r_sig;
endmodule

// File: tb/tb_test_each_bist.sv
// tb_test_each_bist: drives two harness instances (combinational and 2-cycle-latency block models)
module tb_test_each_bist;
   logic clk, rst, start0, abort0, start2, abort2;
   logic [5:0] stim0, stim2, resp0, resp2, d1, d2;
   logic busy0, done0, pass0, busy2, done2, pass2;
   logic [41:0] cnt0, cnt2;
   logic [15:0] sig0, sig2, gold_sig;
   int mode0, mode2;
   int vectors, miscompares;
   logic [5:0] sb_q[$];

   test_each_bist u0 (.clk(clk), .rst(rst), .start(start0), .abort(abort0), .stim(stim0), .resp(resp0),
      .busy(busy0), .done(done0), .pass(pass0), .ones_cnt(cnt0), .signature(sig0));
   test_each_bist #(.RESP_LAT(2)) u2 (.clk(clk), .rst(rst), .start(start2), .abort(abort2), .stim(stim2),
      .resp(resp2), .busy(busy2), .done(done2), .pass(pass2), .ones_cnt(cnt2), .signature(sig2));

   // Reference block: counts per output over all 64 vectors are 16,48,4,60,12,52 (po0..po5)
   function automatic logic [5:0] model(input logic [5:0] p, input int m);
      logic [5:0] r;
      r[0] = p[0] & p[1];
      r[1] = p[0] | p[1];
      r[2] = &p[3:0];
      r[3] = |p[3:0];
      r[4] = p[4] & p[5] & (p[0] | p[1]);
      r[5] = ~r[4];
      if (m == 1) r[2] = &p[2:0];
      if (m == 2) r = '0;
      if (m == 3) r = '1;
      return r;
   endfunction

   assign resp0 = model(stim0, mode0);
   always @(posedge clk) begin
      d1 <= stim2;
      d2 <= d1;
   end
   assign resp2 = model(d2, mode2);

   task automatic calc(input int n, input int m, output logic [41:0] c, output logic [15:0] s);
      logic [5:0] r;
      c = '0;
      s = 16'hFFFF;
      for (int v = 0; v < n; v++) begin
         r = model(6'(v), m);
         for (int i = 0; i < 6; i++) c[i*7 +: 7] = c[i*7 +: 7] + 7'(r[i]);
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'b0, r};
      end
   endtask

   // Pulses start on the combinational instance and follows the whole sweep against the scoreboard
   task automatic sweep0(input int m, input bit poke);
      logic [5:0] e;
      mode0 = m;
      @(negedge clk);
      start0 = 1;
      for (int v = 0; v < 64; v++) sb_q.push_back(6'(v));
      @(negedge clk);
      start0 = 0;
      for (int k = 1; k <= 64; k++) begin
         start0 = poke && k == 10;
         e = sb_q.pop_front();
         vectors++;
         if (stim0 !== e || busy0 !== 1'b1 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep0 cycle %0d: got stim=%0d busy=%b done=%b, want stim=%0d busy=1 done=0",
               k, stim0, busy0, done0, e);
         end
         @(negedge clk);
      end
      start0 = 0;
      vectors++;
      if (done0 !== 1'b1 || busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL done_at_65: got done=%b busy=%b, want done=1 busy=0", done0, busy0);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (stim0 !== 0 || busy0 !== 0 || done0 !== 0 || pass0 !== 0 || cnt0 !== 0 || sig0 !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset: got stim=%0d busy=%b done=%b pass=%b cnt=%h sig=%h, want 0 0 0 0 0 ffff",
            stim0, busy0, done0, pass0, cnt0, sig0);
      end
      rst = 0;
   endtask

   task automatic test_golden;
      logic [41:0] ec;
      logic [15:0] es;
      sweep0(0, 0);
      calc(64, 0, ec, es);
      gold_sig = es;
      vectors++;
      if (cnt0 !== {7'd52, 7'd12, 7'd60, 7'd4, 7'd48, 7'd16} || pass0 !== 1'b1 || sig0 !== es) begin
         miscompares++;
         $display("FAIL golden: got cnt=%h pass=%b sig=%h, want cnt=%h pass=1 sig=%h", cnt0, pass0, sig0, ec, es);
      end
   endtask

   task automatic test_fault;
      logic [41:0] ec;
      logic [15:0] es;
      sweep0(1, 0);
      calc(64, 1, ec, es);
      vectors++;
      if (cnt0[14 +: 7] !== 7'd8 || cnt0 !== ec || pass0 !== 1'b0 || sig0 !== es || sig0 === gold_sig) begin
         miscompares++;
         $display("FAIL fault: got cnt=%h pass=%b sig=%h, want cnt=%h pass=0 sig=%h (not %h)",
            cnt0, pass0, sig0, ec, es, gold_sig);
      end
   endtask

   task automatic test_tied;
      logic [41:0] ec;
      logic [15:0] es;
      sweep0(2, 0);
      calc(64, 2, ec, es);
      vectors++;
      if (cnt0 !== 42'd0 || pass0 !== 1'b0 || sig0 !== es) begin
         miscompares++;
         $display("FAIL tied0: got cnt=%h pass=%b sig=%h, want cnt=0 pass=0 sig=%h", cnt0, pass0, sig0, es);
      end
      sweep0(3, 0);
      calc(64, 3, ec, es);
      vectors++;
      if (cnt0 !== {6{7'd64}} || pass0 !== 1'b0 || sig0 !== es) begin
         miscompares++;
         $display("FAIL tied1: got cnt=%h pass=%b sig=%h, want cnt=%h pass=0 sig=%h", cnt0, pass0, sig0,
            {6{7'd64}}, es);
      end
   endtask

   task automatic test_latency2;
      logic [5:0] e;
      logic [41:0] ec;
      logic [15:0] es;
      mode2 = 0;
      @(negedge clk);
      start2 = 1;
      for (int v = 0; v < 66; v++) sb_q.push_back(v < 64 ? 6'(v) : 6'd63);
      @(negedge clk);
      start2 = 0;
      for (int k = 1; k <= 66; k++) begin
         e = sb_q.pop_front();
         vectors++;
         if (stim2 !== e || busy2 !== 1'b1 || done2 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat2 cycle %0d: got stim=%0d busy=%b done=%b, want stim=%0d busy=1 done=0",
               k, stim2, busy2, done2, e);
         end
         @(negedge clk);
      end
      calc(64, 0, ec, es);
      vectors++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || cnt2 !== ec || pass2 !== 1'b1 || sig2 !== es) begin
         miscompares++;
         $display("FAIL lat2_done_at_67: got done=%b busy=%b cnt=%h pass=%b sig=%h, want 1 0 %h 1 %h",
            done2, busy2, cnt2, pass2, sig2, ec, es);
      end
   endtask

   task automatic test_abort;
      logic [41:0] ec;
      logic [15:0] es;
      mode0 = 0;
      @(negedge clk);
      start0 = 1;
      @(negedge clk);
      start0 = 0;
      repeat (19) @(negedge clk);
      abort0 = 1;
      @(negedge clk);
      abort0 = 0;
      calc(20, 0, ec, es);
      vectors++;
      if (busy0 !== 0 || done0 !== 0 || pass0 !== 0 || cnt0 !== ec || sig0 !== es) begin
         miscompares++;
         $display("FAIL abort: got busy=%b done=%b pass=%b cnt=%h sig=%h, want 0 0 0 %h %h",
            busy0, done0, pass0, cnt0, sig0, ec, es);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (busy0 !== 0 || cnt0 !== ec) begin
         miscompares++;
         $display("FAIL abort_hold: got busy=%b cnt=%h, want busy=0 cnt=%h", busy0, cnt0, ec);
      end
      test_golden();
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start0 = 1;
      @(negedge clk);
      start0 = 0;
      repeat (29) @(negedge clk);
      rst = 1;
      #1;
      vectors++;
      if (stim0 !== 0 || busy0 !== 0 || done0 !== 0 || pass0 !== 0 || cnt0 !== 0 || sig0 !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset_mid: got stim=%0d busy=%b done=%b pass=%b cnt=%h sig=%h, want 0 0 0 0 0 ffff",
            stim0, busy0, done0, pass0, cnt0, sig0);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_back_to_back;
      sweep0(0, 1);
      vectors++;
      if (pass0 !== 1'b1 || sig0 !== gold_sig) begin
         miscompares++;
         $display("FAIL start_while_busy: got pass=%b sig=%h, want pass=1 sig=%h", pass0, sig0, gold_sig);
      end
      @(negedge clk);
      start0 = 1;
      abort0 = 1;
      @(negedge clk);
      start0 = 0;
      abort0 = 0;
      vectors++;
      if (busy0 !== 0 || done0 !== 0 || pass0 !== 0 || sig0 !== gold_sig) begin
         miscompares++;
         $display("FAIL start_abort_done: got busy=%b done=%b pass=%b sig=%h, want 0 0 0 %h",
            busy0, done0, pass0, sig0, gold_sig);
      end
      start0 = 1;
      abort0 = 1;
      @(negedge clk);
      start0 = 0;
      abort0 = 0;
      @(negedge clk);
      vectors++;
      if (busy0 !== 0 || done0 !== 0 || stim0 !== 6'd63) begin
         miscompares++;
         $display("FAIL start_abort_idle: got busy=%b done=%b stim=%0d, want 0 0 63", busy0, done0, stim0);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1;
      start0 = 0;
      abort0 = 0;
      start2 = 0;
      abort2 = 0;
      mode0 = 0;
      mode2 = 0;
      gold_sig = '0;
      test_reset();
      test_golden();
      test_fault();
      test_tied();
      test_latency2();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/test_each_bist.md
Name: test_each_bist

Overview:
- Self-test harness wrapped around the 6-in/6-out combinational regression block.
- Upstream role: on start, sweeps all 2^NUM_IN input vectors into the block's pi bus, one vector per clock.
- Downstream role: captures the block's po bus, counts ones per output, compacts responses into a MISR signature, and raises pass/fail against golden counts.
- Used in regression to check that optimized or remapped netlists of the block stay functionally equivalent.

Parameters:
- NUM_IN, 6, width of stimulus bus; sweep length is 2^NUM_IN vectors.
- NUM_OUT, 6, width of response bus.
- CNT_W, NUM_IN+1, width of each per-output ones counter; must hold 2^NUM_IN.
- RESP_LAT, 0, DUT response latency in clocks (0 = combinational DUT); supported range 0..3.
- SIG_W, 16, MISR width.
- SIG_POLY, 16'h1021, MISR feedback polynomial.
- SIG_SEED, 16'hFFFF, MISR value loaded at start.
- EXP_CNT, {7'd52,7'd12,7'd60,7'd4,7'd48,7'd16}, packed golden ones-counts. Output 0 is in the LSB field.

Ports:
- clk  in  1  Single clock for the block.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Single-cycle pulse; honoured in IDLE and DONE, ignored otherwise.
- abort  in  1  Returns to IDLE from any state; takes priority over start.
- stim  out  NUM_IN  Vector driven to DUT pi[NUM_IN-1:0]; stim[0] drives pi0.
- resp  in  NUM_OUT  DUT po[NUM_OUT-1:0]; resp[0] is po0.
- busy  out  1  High in RUN and DRAIN.
- done  out  1  High in DONE.
- pass  out  1  Valid when done=1.
- ones_cnt  out  NUM_OUT*CNT_W  Per-output ones counters, packed with output 0 in the LSB field.
- signature  out  SIG_W  MISR state.

Behaviour:
- Reset (async): state=IDLE; stim=0; busy=0; done=0; pass=0; ones_cnt=0; signature=SIG_SEED; vector counter=0; valid pipe=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, start=1 -> RUN. Clear counters, load SIG_SEED, set vec=0.
  - RUN: stim=vec (registered), vec increments each cycle. After the cycle presenting vec=2^NUM_IN-1 -> DRAIN (RESP_LAT>0) or DONE (RESP_LAT=0).
  - DRAIN: hold stim at last vector for RESP_LAT cycles, then -> DONE.
  - DONE: sticky. Outputs hold their values; start=1 -> RUN with full re-clear.
  - abort=1 in any state -> IDLE next cycle. Counters and signature keep their partial values; done=0; pass=0.
- Capture:
  - A valid bit travels with each stim through a RESP_LAT-deep shift pipe.
  - With RESP_LAT=0, resp is sampled in the same cycle stim is presented.
  - Exactly 2^NUM_IN samples are taken per run; DRAIN cycles contribute no extra samples.
  - On each valid sample, for each i: ones_cnt[i] += resp[i].
  - On each valid sample: signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp.
- Count width: CNT_W bits, no wrap. The maximum value 2^NUM_IN fits.
- pass: computed on the RUN/DRAIN -> DONE transition as (ones_cnt == EXP_CNT) including the final sample. Registered, so it is valid together with done.
- Latency: start at cycle 0 -> first stim at cycle 1 -> done high at cycle 2^NUM_IN+RESP_LAT+1.
- Simultaneous start and abort: abort wins.
- start while busy: ignored.
- Reset asserted mid-run: immediate return to the reset values above.
- resp is treated as already synchronous to clk; no synchronizer.

Test Plan:
- Golden DUT model, RESP_LAT=0, pulse start -> done at cycle 65; ones_cnt = {52,12,60,4,48,16} (po5..po0); pass=1; signature matches the bench MISR model.
- Fault injection: force po2 = pi0&pi1&pi2 (stuck-through pi3) -> ones_cnt[2]=8, pass=0; signature differs from the golden run.
- resp tied 0 -> all ones_cnt=0, pass=0. resp tied all-1 -> all ones_cnt=64 (no wrap), pass=0.
- RESP_LAT=2 with a 2-stage delayed golden DUT -> exactly 64 samples, counts as in the first scenario, pass=1, done at cycle 67.
- abort at cycle 20 -> IDLE at cycle 21, done=0, ones_cnt frozen at its partial value. A subsequent start gives a clean golden result with pass=1.
- Async rst pulse at cycle 30 mid-run -> all outputs return to reset values immediately. start while busy and start+abort together -> no restart, IDLE respectively.
